// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a word-organised data memory between two requesters,
// with sign/zero-extended sub-word loads and read-modify-write sub-word stores.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_unsigned,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_unsigned,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  state_t         state;
  logic           last_gnt;
  logic           q_port;
  logic           q_we;
  logic           q_unsigned;
  logic [1:0]     q_size;
  logic [1:0]     q_lane;
  logic [DW-1:0]  q_wdata;
  logic [DW-1:0]  merge_buf;

  logic           any_req;
  logic           sel;
  logic           s_we;
  logic           s_unsigned;
  logic [1:0]     s_size;
  logic [DW-1:0]  s_addr;
  logic [DW-1:0]  s_wdata;
  logic           illegal;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [DW-1:0]  load_val;
  logic [DW-1:0]  merged;

  // Winner selection and legality of the winning request
  always_comb begin
    any_req    = p0_req | p1_req;
    sel        = (p0_req & p1_req) ? ~last_gnt : p1_req;
    s_we       = sel ? p1_we       : p0_we;
    s_size     = sel ? p1_size     : p0_size;
    s_unsigned = sel ? p1_unsigned : p0_unsigned;
    s_addr     = sel ? p1_addr     : p0_addr;
    s_wdata    = sel ? p1_wdata    : p0_wdata;
    illegal    = (s_size == 2'b11)
               | ((s_size == SZ_HALF) & s_addr[0])
               | ((s_size == SZ_WORD) & (s_addr[1:0] != 2'b00))
               | (DW'(s_addr[31:2]) >= DEPTH);
  end

  // Load lane extraction/extension and sub-word merge into the buffered word
  always_comb begin
    lane_b = q_lane[1] ? (q_lane[0] ? mem_rd[31:24] : mem_rd[23:16])
                       : (q_lane[0] ? mem_rd[15:8]  : mem_rd[7:0]);
    lane_h = q_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (q_size)
      SZ_BYTE: load_val = q_unsigned ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_val = q_unsigned ? {16'h0000, lane_h}   : {{16{lane_h[15]}}, lane_h};
      default: load_val = mem_rd;
    endcase
    merged = merge_buf;
    if (q_size == SZ_BYTE) merged[{q_lane, 3'b000} +: 8] = q_wdata[7:0];
    else                   merged[{q_lane[1], 4'b0000} +: 16] = q_wdata[15:0];
  end

  // Grant and memory write strobes; writes are blocked in any reset cycle
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    mem_we = 1'b0;
    mem_wd = '0;
    if ((state == IDLE) && any_req && !rst) begin
      p0_gnt = ~sel;
      p1_gnt = sel;
    end
    if ((state == ACCESS) && q_we && (q_size == SZ_WORD)) begin
      mem_we = ~rst;
      mem_wd = q_wdata;
    end else if (state == WRITE) begin
      mem_we = ~rst;
      mem_wd = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      q_port     <= 1'b0;
      q_we       <= 1'b0;
      q_unsigned <= 1'b0;
      q_size     <= 2'b00;
      q_lane     <= 2'b00;
      q_wdata    <= '0;
      merge_buf  <= '0;
      mem_a      <= '0;
      p0_done    <= 1'b0;
      p0_err     <= 1'b0;
      p0_rdata   <= '0;
      p1_done    <= 1'b0;
      p1_err     <= 1'b0;
      p1_rdata   <= '0;
    end else begin
      p0_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_done <= 1'b0;
      p1_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_gnt   <= sel;
            q_port     <= sel;
            q_we       <= s_we;
            q_size     <= s_size;
            q_unsigned <= s_unsigned;
            q_lane     <= s_addr[1:0];
            q_wdata    <= s_wdata;
            if (illegal) begin
              state   <= DONE;
              p0_done <= ~sel;
              p0_err  <= ~sel;
              p1_done <= sel;
              p1_err  <= sel;
            end else begin
              state <= ACCESS;
              mem_a <= {s_addr[31:2], 2'b00};
            end
          end
        end
        ACCESS: begin
          if (q_we && (q_size != SZ_WORD)) begin
            merge_buf <= mem_rd;
            state     <= WRITE;
          end else begin
            if (!q_we) begin
              if (q_port) p1_rdata <= load_val;
              else        p0_rdata <= load_val;
            end
            state   <= DONE;
            p0_done <= ~q_port;
            p1_done <= q_port;
          end
        end
        WRITE: begin
          state   <= DONE;
          p0_done <= ~q_port;
          p1_done <= q_port;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port, word-organised data memory between two requesters: port 0 (core load/store unit) and port 1 (program loader / debug port). Arbitrates round-robin and performs byte/halfword loads with sign or zero extension. Byte/halfword stores use a read-modify-write sequence. Sits between the requesters and the data memory, and is the only driver of the memory's address, write-data and write-enable inputs.

## Interface
- `DEPTH`, 64: number of 32-bit words in the attached memory; word indices at or above `DEPTH` are errors.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `p0_req`, `p1_req` in 1: request valid; hold with fields stable until `gnt`.
- `pN_we` in 1: 1 = store, 0 = load.
- `pN_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `pN_unsigned` in 1: zero-extend sub-word loads (else sign-extend).
- `pN_addr` in 32: byte address.
- `pN_wdata` in 32: store data, right-aligned for sub-word stores.
- `pN_gnt` out 1: one-cycle pulse; the request was latched this cycle.
- `pN_done` out 1: one-cycle completion pulse.
- `pN_rdata` out 32: load result, valid while `pN_done` is high, otherwise held.
- `pN_err` out 1: qualifies `pN_done`; access was rejected with no memory write.
- `mem_a` out 32: word-aligned byte address {addr[31:2],2'b00}.
- `mem_wd` out 32: memory write data.
- `mem_we` out 1: memory write enable.
- `mem_rd` in 32: memory read data, combinational on `mem_a`.

## Operation
- FSM states: IDLE, ACCESS, WRITE, DONE.
- **IDLE**
  - If any `req` is high: pick the winner, latch its we/size/unsigned/addr/wdata/port id, pulse its `gnt`, go to ACCESS.
  - If the request is illegal, go straight to DONE with err set.
- **Illegal request** (checked in IDLE), any of:
  - size = 11;
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - addr[31:2] ≥ `DEPTH`.
- **Arbitration**
  - One requester high: it wins.
  - Both high: the port not granted last wins.
  - The last-granted register updates on every grant.
  - Reset value of last-granted is 1, so p0 wins the first tie.
- **ACCESS**
  - `mem_a` = latched word address.
  - Load: extract the lane from `mem_rd`, extend it, register it into the winner's rdata; go to DONE.
  - Word store: `mem_we` = 1, `mem_wd` = wdata; go to DONE.
  - Sub-word store: register `mem_rd` into the merge buffer; go to WRITE.
- **WRITE**
  - `mem_we` = 1.
  - `mem_wd` = merge buffer with the addressed byte lane (addr[1:0]) or half lane (addr[1]) replaced by wdata[7:0] or wdata[15:0].
  - Go to DONE.
- **DONE**: pulse the winner's `done` (plus `err` if illegal); go to IDLE. No grant is issued in DONE.
- Lane order is little-endian: byte 0 = bits [7:0].
- Sign extension copies bit 7 (byte) or bit 15 (half).
- `pN_rdata` of the non-winning port is never modified.
- Outside ACCESS and WRITE: `mem_we` = 0, `mem_wd` = 0, `mem_a` holds its last value.
- `mem_we` is gated by `~rst`, so no memory write can occur in any cycle with `rst` high.

## Timing
- **Reset** (rst high at an edge):
  - State goes to IDLE; last-granted goes to 1.
  - All `gnt`, `done`, `err` = 0.
  - All `rdata` = 0; merge buffer = 0.
  - `mem_a` = 0, `mem_we` = 0, `mem_wd` = 0.
  - Any in-flight access is dropped with no `done`. A half-finished RMW leaves memory unchanged.
- **Latency**, counted from the cycle where `gnt` is high (cycle 0):
  - Load and word store: `done` in cycle 2; word write committed at the edge ending cycle 1.
  - Sub-word store: read in cycle 1, write at the edge ending cycle 2, `done` in cycle 3.
  - Illegal request: `done`+`err` in cycle 1.
- **Throughput**
  - Next grant no earlier than the IDLE cycle after DONE: one access per 3 cycles (4 for sub-word stores).
  - A `req` still high in the IDLE cycle after `done` is a new request.
- **Simultaneous events**
  - A losing requester keeps `req` high; it is granted at the next IDLE.
  - Under continuous contention, grants strictly alternate p0, p1, p0, ...

## Test plan
- **Word round-trip**
  - Stimulus: p0 stores 0xDEADBEEF at 0x10; p0 then loads 0x10.
  - Response: `mem_we` pulses in cycle 1 with `mem_a` = 0x10; the load returns 0xDEADBEEF with `done` in cycle 2.
- **Byte store RMW**
  - Stimulus: word 0x10 = 0x11223344; p1 stores byte 0xAA at 0x12.
  - Response: memory = 0x11AA3344; `done` in cycle 3; exactly one `mem_we` cycle.
- **Sub-word loads**
  - Stimulus: word 0x11AA3344 at 0x10; load byte at 0x12, signed then unsigned; load signed half at 0x12.
  - Response: 0xFFFFFFAA, then 0x000000AA, then 0x000011AA.
- **Contention**
  - Stimulus: p0 and p1 both hold `req` for 6 accesses from reset.
  - Response: grant order p0, p1, p0, p1, p0, p1; no lost or duplicated `done`.
- **Errors**
  - Stimulus: word store at 0x12; half load at 0x11; word store at 0x100 (index 64 with `DEPTH` = 64).
  - Response: each gets `done`+`err` in cycle 1; `mem_we` stays 0 throughout.
- **Reset mid-RMW**
  - Stimulus: assert `rst` in cycle 2 of a byte store.
  - Response: `mem_we` never asserts; memory is unchanged; outputs hold reset values; a new request afterwards is granted normally.
